// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment definitions.
// Glyph codes are 7-bit, bit order g..a, active-high (1 = segment lit).
package seg7_pkg;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG7_GLYPH_0 = 7'h3F;
  localparam seg_code_t SEG7_GLYPH_1 = 7'h06;
  localparam seg_code_t SEG7_GLYPH_2 = 7'h5B;
  localparam seg_code_t SEG7_GLYPH_3 = 7'h4F;
  localparam seg_code_t SEG7_GLYPH_4 = 7'h66;
  localparam seg_code_t SEG7_GLYPH_5 = 7'h6D;
  localparam seg_code_t SEG7_GLYPH_6 = 7'h7D;
  localparam seg_code_t SEG7_GLYPH_7 = 7'h07;
  localparam seg_code_t SEG7_GLYPH_8 = 7'h7F;
  localparam seg_code_t SEG7_GLYPH_9 = 7'h6F;
  localparam seg_code_t SEG7_GLYPH_A = 7'h77;
  localparam seg_code_t SEG7_GLYPH_B = 7'h7C;
  localparam seg_code_t SEG7_GLYPH_C = 7'h39;
  localparam seg_code_t SEG7_GLYPH_D = 7'h5E;
  localparam seg_code_t SEG7_GLYPH_E = 7'h79;
  localparam seg_code_t SEG7_GLYPH_F = 7'h71;

  // Nibble reported for a pattern that is not a hex glyph.
  localparam logic [3:0] SEG7_ILLEGAL_NIBBLE = 4'h0;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational segment code -> {legal, nibble}.
// Kept standalone so other display-side checkers can reuse it.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  seg_code_t  code_i,
  output logic       legal_o,
  output logic [3:0] nibble_o
);

  // Map each legal glyph to its hex value; everything else is illegal.
  always_comb begin
    legal_o  = 1'b1;
    nibble_o = SEG7_ILLEGAL_NIBBLE;
    case (code_i)
      SEG7_GLYPH_0: nibble_o = 4'h0;
      SEG7_GLYPH_1: nibble_o = 4'h1;
      SEG7_GLYPH_2: nibble_o = 4'h2;
      SEG7_GLYPH_3: nibble_o = 4'h3;
      SEG7_GLYPH_4: nibble_o = 4'h4;
      SEG7_GLYPH_5: nibble_o = 4'h5;
      SEG7_GLYPH_6: nibble_o = 4'h6;
      SEG7_GLYPH_7: nibble_o = 4'h7;
      SEG7_GLYPH_8: nibble_o = 4'h8;
      SEG7_GLYPH_9: nibble_o = 4'h9;
      SEG7_GLYPH_A: nibble_o = 4'hA;
      SEG7_GLYPH_B: nibble_o = 4'hB;
      SEG7_GLYPH_C: nibble_o = 4'hC;
      SEG7_GLYPH_D: nibble_o = 4'hD;
      SEG7_GLYPH_E: nibble_o = 4'hE;
      SEG7_GLYPH_F: nibble_o = 4'hF;
      default:      legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: receiver for a multiplexed seven-segment display.
// Samples an/dp/segments, waits for each digit to settle, decodes it and
// presents a complete NUM_DIGITS-digit frame with a one-cycle strobe.
// Optional build macro SEG7_SCAN_ORDER_CHECK_EN: a digit repeated before the
// frame completes flags seg_error and restarts the frame from that digit.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    d,
  input  logic                    e,
  input  logic                    f,
  input  logic                    g,
  input  logic                    dp,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   digit_error,
  output logic                    frame_valid,
  output logic                    frame_strobe,
  output logic                    seg_error
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [SW-1:0]           sample_q, prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    same, fire;
  logic [NUM_DIGITS-1:0]   an_s;
  logic                    dp_s;
  seg_code_t               seg_s;
  logic                    legal;
  logic [3:0]              nibble;
  logic                    an_any, an_multi, capture, commit, order_viol;
  logic [4*NUM_DIGITS-1:0] shadow_nib_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_err_q;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;

  // Register inputs inverted to active-high, plus one-cycle history.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sample_q <= '0;
      prev_q   <= '0;
    end else begin
      sample_q <= ~{an, dp, g, f, e, d, c, b, a};
      prev_q   <= sample_q;
    end
  end

  // Stability counter; fire only on the cycle it first lands on STABLE_CYCLES-1.
  always_comb begin
    same = (sample_q == prev_q);
    if (!same)                cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 1'b1;
    fire = (cnt_d == CNT_FIRE) && (!same || (cnt_q != cnt_d));
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign an_s  = sample_q[SW-1:8];
  assign dp_s  = sample_q[7];
  assign seg_s = seg_code_t'(sample_q[6:0]);

  seg7_glyph_decode u_decode (
    .code_i   (seg_s),
    .legal_o  (legal),
    .nibble_o (nibble)
  );

  assign an_any   = |an_s;
  assign an_multi = |(an_s & (an_s - AN_ONE));
  assign capture  = fire && an_any && !an_multi;
  assign commit   = &seen_q;

`ifdef SEG7_SCAN_ORDER_CHECK_EN
  // A repeat is only a violation while the frame is still being collected.
  assign order_viol = capture && !commit && |(seen_q & an_s);
`else
  assign order_viol = 1'b0;
`endif

  // Seen mask: cleared on commit, a same-cycle capture lands in the new frame.
  always_comb begin
    seen_d = seen_q;
    if (commit) seen_d = '0;
    if (capture) begin
      if (order_viol) seen_d = an_s;
      else            seen_d = seen_d | an_s;
    end
  end

  // Shadow storage for the frame under construction.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shadow_nib_q <= '0;
      shadow_dp_q  <= '0;
      shadow_err_q <= '0;
      seen_q       <= '0;
    end else begin
      seen_q <= seen_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && an_s[i]) begin
          shadow_nib_q[4*i +: 4] <= nibble;
          shadow_dp_q[i]         <= dp_s;
          shadow_err_q[i]        <= !legal;
        end
      end
    end
  end

  // Frame commit and event outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value        <= '0;
      dp_mask      <= '0;
      digit_error  <= '0;
      frame_valid  <= 1'b0;
      frame_strobe <= 1'b0;
      seg_error    <= 1'b0;
    end else begin
      frame_strobe <= commit;
      seg_error    <= (fire && an_multi) || (capture && !legal) || order_viol;
      if (commit) begin
        value       <= shadow_nib_q;
        dp_mask     <= shadow_dp_q;
        digit_error <= shadow_err_q;
        frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed self-checking bench for seg7_scan_capture (default parameters).
module tb_seg7_scan_capture;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a, b, c, d, e, f, g, dp;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  dp_mask, digit_error;
  logic        frame_valid, frame_strobe, seg_error;

  int total = 0;
  int bad   = 0;
  int n_strobe = 0;
  int n_segerr = 0;
  int s0, e0;

  seg7_scan_capture dut (
    .clock(clock), .reset_n(reset_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
    .value(value), .dp_mask(dp_mask), .digit_error(digit_error),
    .frame_valid(frame_valid), .frame_strobe(frame_strobe), .seg_error(seg_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_strobe === 1'b1) n_strobe++;
    if (seg_error === 1'b1)    n_segerr++;
  end

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'h3F;  1: glyph = 7'h06;  2: glyph = 7'h5B;  3: glyph = 7'h4F;
      4: glyph = 7'h66;  5: glyph = 7'h6D;  6: glyph = 7'h7D;  7: glyph = 7'h07;
      8: glyph = 7'h7F;  9: glyph = 7'h6F; 10: glyph = 7'h77; 11: glyph = 7'h7C;
      12: glyph = 7'h39; 13: glyph = 7'h5E; 14: glyph = 7'h79; default: glyph = 7'h71;
    endcase
  endfunction

  // Drive one active-high pattern (an_hot, code, dp) for n cycles.
  task automatic drive(input logic [3:0] an_hot, input logic [6:0] code,
                       input logic dp_on, input int n);
    {g, f, e, d, c, b, a} = ~code;
    dp = ~dp_on;
    an = ~an_hot;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic blank(input int n);
    drive(4'b0000, 7'h00, 1'b0, n);
  endtask

  task automatic snap();
    s0 = n_strobe;
    e0 = n_segerr;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {g, f, e, d, c, b, a} = 7'($urandom);
      dp = 1'($urandom);
      an = 4'($urandom);
      @(posedge clock); #1;
    end
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h want=0000", value); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b want=0", frame_valid); end
    total++; if (frame_strobe !== 1'b0) begin bad++; $display("FAIL reset_frame_strobe got=%b want=0", frame_strobe); end
    total++; if (seg_error !== 1'b0) begin bad++; $display("FAIL reset_seg_error got=%b want=0", seg_error); end
    total++; if (dp_mask !== 4'h0 || digit_error !== 4'h0) begin bad++; $display("FAIL reset_masks got=%b/%b want=0000/0000", dp_mask, digit_error); end
    blank(1);
    reset_n = 1'b1;
    blank(4);
  endtask

  task automatic test_clean_scan();
    snap();
    drive(4'b0001, glyph(7), 1'b0, 8);
    drive(4'b0010, glyph(0), 1'b0, 8);
    drive(4'b0100, glyph(0), 1'b0, 8);
    drive(4'b1000, glyph(0), 1'b0, 8);
    blank(4);
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL clean_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (n_segerr - e0 !== 0) begin bad++; $display("FAIL clean_seg_errors got=%0d want=0", n_segerr - e0); end
    total++; if (value !== 16'h0007) begin bad++; $display("FAIL clean_value got=%h want=0007", value); end
    total++; if (dp_mask !== 4'b0000) begin bad++; $display("FAIL clean_dp_mask got=%b want=0000", dp_mask); end
    total++; if (digit_error !== 4'b0000) begin bad++; $display("FAIL clean_digit_error got=%b want=0000", digit_error); end
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL clean_frame_valid got=%b want=1", frame_valid); end
  endtask

  task automatic test_glitch();
    snap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) drive(4'(1 << i), glyph(i + 1), 1'b0, 3);
    end
    blank(2);
    total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL glitch_strobes got=%0d want=0", n_strobe - s0); end
    total++; if (n_segerr - e0 !== 0) begin bad++; $display("FAIL glitch_seg_errors got=%0d want=0", n_segerr - e0); end
    total++; if (value !== 16'h0007) begin bad++; $display("FAIL glitch_value got=%h want=0007", value); end
  endtask

  task automatic test_illegal_glyph();
    snap();
    drive(4'b0001, glyph(5), 1'b0, 8);
    drive(4'b0010, glyph(5), 1'b0, 8);
    drive(4'b0100, 7'h00,    1'b0, 8);
    drive(4'b1000, glyph(5), 1'b0, 8);
    blank(4);
    total++; if (n_segerr - e0 !== 1) begin bad++; $display("FAIL illegal_seg_errors got=%0d want=1", n_segerr - e0); end
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL illegal_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (value !== 16'h5055) begin bad++; $display("FAIL illegal_value got=%h want=5055", value); end
    total++; if (digit_error !== 4'b0100) begin bad++; $display("FAIL illegal_digit_error got=%b want=0100", digit_error); end
  endtask

  task automatic test_multi_hot();
    snap();
    drive(4'b0011, glyph(8), 1'b0, 8);
    blank(2);
    total++; if (n_segerr - e0 !== 1) begin bad++; $display("FAIL multi_seg_errors got=%0d want=1", n_segerr - e0); end
    drive(4'b0010, glyph(10), 1'b0, 8);
    drive(4'b0100, glyph(10), 1'b0, 8);
    drive(4'b1000, glyph(10), 1'b0, 8);
    blank(4);
    total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL multi_no_capture_strobes got=%0d want=0", n_strobe - s0); end
    total++; if (value !== 16'h5055) begin bad++; $display("FAIL multi_value_hold got=%h want=5055", value); end
    drive(4'b0001, glyph(10), 1'b0, 8);
    blank(4);
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL multi_complete_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (value !== 16'hAAAA) begin bad++; $display("FAIL multi_complete_value got=%h want=AAAA", value); end
  endtask

`ifdef SEG7_SCAN_ORDER_CHECK_EN
  task automatic test_dp_order();
    snap();
    drive(4'b0001, glyph(3), 1'b0, 8);
    drive(4'b0010, glyph(3), 1'b0, 8);
    blank(2);
    drive(4'b0010, glyph(3), 1'b0, 8);
    drive(4'b0100, glyph(3), 1'b0, 8);
    drive(4'b1000, glyph(3), 1'b1, 8);
    blank(4);
    total++; if (n_segerr - e0 !== 1) begin bad++; $display("FAIL order_seg_errors got=%0d want=1", n_segerr - e0); end
    total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL order_early_strobes got=%0d want=0", n_strobe - s0); end
    drive(4'b0001, glyph(3), 1'b0, 8);
    blank(4);
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL order_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (value !== 16'h3333) begin bad++; $display("FAIL order_value got=%h want=3333", value); end
    total++; if (dp_mask !== 4'b1000) begin bad++; $display("FAIL order_dp_mask got=%b want=1000", dp_mask); end
  endtask
`else
  task automatic test_dp_duplicate();
    snap();
    drive(4'b0001, glyph(1), 1'b0, 8);
    drive(4'b0010, glyph(2), 1'b0, 8);
    blank(2);
    drive(4'b0010, glyph(4), 1'b0, 8);
    drive(4'b0100, glyph(6), 1'b0, 8);
    drive(4'b1000, glyph(8), 1'b1, 8);
    blank(4);
    total++; if (n_segerr - e0 !== 0) begin bad++; $display("FAIL dup_seg_errors got=%0d want=0", n_segerr - e0); end
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL dup_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (value !== 16'h8641) begin bad++; $display("FAIL dup_value got=%h want=8641", value); end
    total++; if (dp_mask !== 4'b1000) begin bad++; $display("FAIL dup_dp_mask got=%b want=1000", dp_mask); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    snap();
    drive(4'b0001, glyph(9), 1'b0, 8);
    drive(4'b0010, glyph(9), 1'b0, 8);
    reset_n = 1'b0;
    blank(2);
    reset_n = 1'b1;
    drive(4'b0100, glyph(9), 1'b0, 8);
    drive(4'b1000, glyph(9), 1'b0, 8);
    blank(4);
    total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL midreset_strobes got=%0d want=0", n_strobe - s0); end
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL midreset_value got=%h want=0000", value); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL midreset_frame_valid got=%b want=0", frame_valid); end
  endtask

  initial begin
    reset_n = 1'b0;
    {g, f, e, d, c, b, a} = 7'h7F;
    dp = 1'b1;
    an = 4'hF;
    @(posedge clock); #1;
    test_reset();
    test_clean_scan();
    test_glitch();
    test_illegal_glyph();
    test_multi_hot();
`ifdef SEG7_SCAN_ORDER_CHECK_EN
    test_dp_order();
`else
    test_dp_duplicate();
`endif
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
